seq_multiplier: RTL and testbench

//   Iterative shift-add unsigned multiplier: the datapath stage fed by port_t

---
 rtl/mult_pkg.sv | 23 ++
 rtl/seq_multiplier.sv | 100 ++++++++++
 tb/tb_seq_multiplier.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/mult_pkg.sv
// +----------------------------------------------------------------------+
// | mult_pkg : shared state encoding and operand/product types for       |
// |            seq_multiplier.                                           |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
`default_nettype none

package mult_pkg;

  localparam int MULT_WIDTH = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } mult_state_t;

  typedef logic [MULT_WIDTH-1:0]   mult_operand_t;
  typedef logic [2*MULT_WIDTH-1:0] mult_product_t;

endpackage

`default_nettype wire

// File: rtl/seq_multiplier.sv
// +----------------------------------------------------------------------+
// | seq_multiplier : iterative shift-add unsigned multiplier with        |
// |                  valid/ready operand and product interfaces.         |
// | Option   : MULT_EARLY_TERM_EN stops iterating once multiplier is 0.  |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
`default_nettype none

module seq_multiplier
  import mult_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_m,
  output logic               busy
);

  localparam int              CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

  mult_state_t        state;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic [CW-1:0]      count;

  logic [2*WIDTH-1:0] acc_next;
  logic [WIDTH-1:0]   mplier_next;
  logic               calc_done;

  always_comb begin
    acc_next    = mplier[0] ? (acc + mcand) : acc;
    mplier_next = mplier >> 1;
`ifdef MULT_EARLY_TERM_EN
    // Remaining multiplier bits all zero: the accumulator is already final.
    calc_done   = (count == LAST) || (mplier_next == '0);
`else
    calc_done   = (count == LAST);
`endif
    in_ready    = (state == IDLE);
    busy        = (state != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      acc       <= '0;
      mcand     <= '0;
      mplier    <= '0;
      count     <= '0;
      out_valid <= 1'b0;
      out_m     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            mcand  <= {{WIDTH{1'b0}}, in_a};
            mplier <= in_b;
            acc    <= '0;
            count  <= '0;
            state  <= CALC;
          end
        end
        CALC: begin
          acc    <= acc_next;
          mcand  <= mcand << 1;
          mplier <= mplier_next;
          count  <= count + 1'b1;
          if (calc_done) begin
            out_m     <= acc_next;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          // out_m is left untouched so the last product remains visible.
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_seq_multiplier.sv
// Directed self-checking bench for seq_multiplier: vector table plus
// hand-written backpressure, ignored-input and mid-operation reset cases.
`default_nettype none

module tb_seq_multiplier;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [4:0] in_a;
  logic [4:0] in_b;
  logic       out_valid;
  logic       out_ready;
  logic [9:0] out_m;
  logic       busy;

  int checks = 0;
  int errors = 0;

  seq_multiplier #(.WIDTH(5)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_m     (out_m),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] a;
    logic [4:0] b;
    logic [9:0] m;
    int         lat_full;
    int         lat_early;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int exp_lat(input vec_t v);
`ifdef MULT_EARLY_TERM_EN
    return v.lat_early;
`else
    return v.lat_full;
`endif
  endfunction

  // Presents operands before an edge; returns just after the accept edge.
  task automatic start_op(input logic [4:0] a, input logic [4:0] b);
    @(negedge clk);
    in_a     = a;
    in_b     = b;
    in_valid = 1'b1;
    check("in_ready_idle", in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("busy_calc", busy, 1);
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      #1;
      if (out_valid) begin
        lat = k;
        break;
      end
    end
  endtask

  initial begin
    int lat;
    bit seen;

    vecs[0] = '{5'd31, 5'd31, 10'd961, 5, 5};
    vecs[1] = '{5'd3,  5'd7,  10'd21,  5, 3};
    vecs[2] = '{5'd0,  5'd13, 10'd0,   5, 4};
    vecs[3] = '{5'd13, 5'd0,  10'd0,   5, 1};
    vecs[4] = '{5'd1,  5'd16, 10'd16,  5, 5};
    vecs[5] = '{5'd25, 5'd6,  10'd150, 5, 3};
    vecs[6] = '{5'd9,  5'd1,  10'd9,   5, 1};
    vecs[7] = '{5'd17, 5'd2,  10'd34,  5, 2};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    out_ready = 1'b1;

    // Reset state, during and after reset
    #3;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_m", out_m, 0);
    check("rst_busy", busy, 0);
    check("rst_in_ready", in_ready, 1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rel_out_valid", out_valid, 0);
    check("rel_out_m", out_m, 0);
    check("rel_busy", busy, 0);
    check("rel_in_ready", in_ready, 1);

    // Table-driven products at full out_ready
    for (int i = 0; i < 8; i++) begin
      start_op(vecs[i].a, vecs[i].b);
      wait_valid(lat);
      check($sformatf("latency[%0d]", i), lat, exp_lat(vecs[i]));
      check($sformatf("product[%0d]", i), out_m, vecs[i].m);
      check($sformatf("in_ready_done[%0d]", i), in_ready, 0);
      @(posedge clk);
      #1;
      check($sformatf("valid_one_cycle[%0d]", i), out_valid, 0);
      check($sformatf("in_ready_after[%0d]", i), in_ready, 1);
      check($sformatf("m_kept[%0d]", i), out_m, vecs[i].m);
    end

    // Backpressure: 3*7 held while out_ready low
    out_ready = 1'b0;
    start_op(5'd3, 5'd7);
    wait_valid(lat);
    check("bp_latency", lat, exp_lat(vecs[1]));
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1;
      check("bp_valid_held", out_valid, 1);
      check("bp_m_held", out_m, 21);
      check("bp_in_ready", in_ready, 0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_release_valid", out_valid, 0);
    check("bp_release_in_ready", in_ready, 1);
    check("bp_release_busy", busy, 0);

    // Operands offered during CALC are ignored
    start_op(5'd2, 5'd3);
    in_valid = 1'b1;
    in_a     = 5'd9;
    in_b     = 5'd9;
    wait_valid(lat);
    in_valid = 1'b0;
    check("ign_product", out_m, 6);
    seen = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      #1;
      if (out_valid || busy) seen = 1'b1;
    end
    check("ign_no_second", seen, 0);

    // Reset mid-CALC discards the operation
    start_op(5'd5, 5'd5);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_out_m", out_m, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_in_ready", in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk);
      #1;
      if (out_valid || busy) seen = 1'b1;
    end
    check("mid_rst_no_product", seen, 0);

    // Reset while holding a product in DONE
    out_ready = 1'b0;
    start_op(5'd9, 5'd1);
    wait_valid(lat);
    check("done_rst_latency", lat, exp_lat(vecs[6]));
    check("done_rst_m", out_m, 9);
    #2;
    rst_n = 1'b0;
    #1;
    check("done_rst_out_valid", out_valid, 0);
    check("done_rst_out_m", out_m, 0);
    check("done_rst_busy", busy, 0);
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("done_rst_idle", in_ready, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
